hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Central pipeline-control block for the 5-stage ARM datapath (IF, ID, EX, MEM, WB).
- Detects load-use hazards and taken-branch flushes, and freezes the pipeline while data memory is busy.
- Drives the write enables, bubbles and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sits beside the forwarding unit: it covers the cases forwarding cannot resolve, and its ID/EX bubble feeds the regWriteEX / RdEX fields that forwarding consumes.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before a fault.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memReadEX  in  1  instruction in EX is a load.
- RdEX  in  5  destination register of the instruction in EX.
- Rn_ID  in  5  first source register of the instruction in ID.
- Rm_ID  in  5  second source register of the instruction in ID.
- usesRm_ID  in  1  ID instruction reads Rm (register-form ALU op or store data).
- branchTakenEX  in  1  branch in EX resolved taken.
- memReqMEM  in  1  instruction in MEM issues a data-memory access.
- memReadyMEM  in  1  data memory completes the access this cycle.
- pcWrite  out  1  PC register enable.
- ifidWrite  out  1  IF/ID register enable.
- ifidFlush  out  1  IF/ID loads a NOP.
- idexBubble  out  1  ID/EX loads control zeros (regWrite=0, memWrite=0, flagEn=0, branch=0).
- pipeHold  out  1  ID/EX and EX/MEM hold their contents.
- memwbBubble  out  1  MEM/WB loads control zeros.
- memFault  out  1  sticky memory-timeout error.
- stallCycles  out  CNT_W  saturating count of stall cycles.
- flushCount  out  CNT_W  saturating count of branch flushes.

Behaviour:
- FSM states: RUN, MEM_WAIT, FAULT (2-bit state register).
- Outputs are combinational from state and inputs. Default: pcWrite=1 and ifidWrite=1; all other control outputs 0.
- Reset:
  - state=RUN, both counters=0, memFault=0, wait counter=0.
  - During a reset cycle, outputs take their RUN-state values. Reset takes priority in every state, including mid-wait and FAULT.
- RUN, checked in priority order:
  1. memReqMEM & !memReadyMEM:
     - Outputs: pcWrite=0, ifidWrite=0, pipeHold=1, memwbBubble=1.
     - Next state MEM_WAIT; wait counter loads 1; stallCycles increments.
  2. branchTakenEX:
     - Outputs: ifidFlush=1, idexBubble=1, pcWrite=1 (PC takes the target).
     - flushCount increments.
     - A load-use condition in the same cycle is ignored, because the ID instruction is being flushed.
  3. Load-use: memReadEX & RdEX!=31 & (RdEX==Rn_ID | (usesRm_ID & RdEX==Rm_ID)):
     - Outputs: pcWrite=0, ifidWrite=0, idexBubble=1.
     - stallCycles increments.
     - Exactly one bubble is inserted. On the next cycle the load is in MEM and forwarding covers the dependency; the bubble carries regWriteEX=0, so the hazard is not re-detected.
  4. Otherwise: defaults.
  - A memory access completing in the same cycle it is requested (memReqMEM & memReadyMEM) causes no stall.
- MEM_WAIT:
  - Outputs: the freeze outputs from RUN item 1, held every cycle, including the ready cycle.
  - stallCycles increments every cycle.
  - On memReadyMEM: next state RUN. On that cycle the MEM/WB register takes the completed result (memwbBubble=0) while PC, IF/ID and pipeHold stay frozen.
  - A branch in EX is not acted on while waiting. EX is frozen, so branchTakenEX remains asserted and is serviced in RUN on the following cycle.
  - Wait counter increments each cycle without ready. If it reaches MEM_TIMEOUT with no ready: next state FAULT.
- FAULT:
  - Outputs: pcWrite=0, ifidWrite=0, pipeHold=1, memwbBubble=1, memFault=1.
  - All inputs are ignored; only reset exits this state.
  - Counters freeze.
- Counters:
  - Unsigned, saturating at 2^CNT_W-1 with no wrap.
  - Increments happen on the clock edge following the qualifying cycle.

Decomposition:
- Shared package pipeline_pkg:
  - state enum hz_state_t {RUN, MEM_WAIT, FAULT};
  - localparam XZR = 5'd31;
  - the control-zero bundle used for bubbles.
  - The forwarding unit should adopt XZR from this package.
- Sub-module sat_counter (parameter W, ports clk, reset, inc, count), instantiated twice.

Test Plan:
- Load-use:
  - Stimulus: LDUR X2 in EX (memReadEX=1, RdEX=2), ADD in ID with Rn_ID=2.
  - Required: one cycle with pcWrite=0, ifidWrite=0, idexBubble=1. Next cycle, with RdEX=0 and memReadEX=0, defaults return. stallCycles=1.
- Load to XZR and Rm-only match:
  - Stimulus: RdEX=31 with Rn_ID=31 → no stall.
  - Stimulus: RdEX=5, Rm_ID=5, usesRm_ID=0 → no stall.
  - Stimulus: RdEX=5, Rm_ID=5, usesRm_ID=1 → stall.
- Branch with load-use in the same cycle:
  - Stimulus: branchTakenEX=1 plus a load-use match.
  - Required: ifidFlush=1, idexBubble=1, pcWrite=1. flushCount=1, stallCycles=0.
- Memory wait of 3 cycles:
  - Stimulus: memReqMEM=1, memReadyMEM low for 3 cycles, then high.
  - Required: pipeHold=1 for 4 cycles; memwbBubble=1 for the first 3 only; stallCycles=4. Return to RUN.
- Timeout:
  - Stimulus: memReadyMEM held low with MEM_TIMEOUT=4.
  - Required: FAULT after 4 wait cycles; memFault=1 and stays set.
  - Stimulus: reset pulse (also asserted mid-wait in a second run).
  - Required: memFault=0, state RUN, counters 0.
- Saturation:
  - Stimulus: CNT_W=3 with 10 stall cycles.
  - Required: stallCycles=7, with no wrap.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the 5-stage pipeline control path.
//   - hz_state_t : hazard/memory-wait FSM states
//   - XZR        : zero-register index; writes to it never create a dependency
//   - ctrl_t     : per-instruction control bundle, CTRL_ZERO is the bubble value
//   - is_load_use: load-use dependency test between EX and ID
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_t;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic flag_en;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '0;

  // A load into XZR produces nothing, so it cannot feed a later instruction.
  function automatic logic is_load_use(input logic       mem_read,
                                       input logic [4:0] rd,
                                       input logic [4:0] rn,
                                       input logic [4:0] rm,
                                       input logic       uses_rm);
    return mem_read && (rd != XZR) && ((rd == rn) || (uses_rm && (rd == rm)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Unsigned up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk   in   system clock
//     reset in   synchronous active-high clear
//     inc   in   count this cycle
//     count out  current count, W bits
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline control for the IF/ID/EX/MEM/WB datapath: load-use stalls,
//   taken-branch flushes and whole-pipe freeze while data memory is busy,
//   with a timeout that parks the pipe in a sticky fault.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     memReadEX, RdEX   load in EX and its destination
//     Rn_ID, Rm_ID,
//     usesRm_ID         source registers of the ID instruction
//     branchTakenEX     branch in EX resolved taken
//     memReqMEM,
//     memReadyMEM       data-memory request / completion in MEM
//     pcWrite, ifidWrite, ifidFlush, idexBubble,
//     pipeHold, memwbBubble     pipeline register controls
//     memFault          sticky memory-timeout error
//     stallCycles, flushCount   saturating performance counters
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   RUN      | normal flow; load-use stall, branch flush or memory miss entry
//   MEM_WAIT | data memory busy; PC, IF/ID, ID/EX, EX/MEM frozen
//   FAULT    | memory never answered; pipe frozen until reset
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memReadEX,
  input  logic [4:0]       RdEX,
  input  logic [4:0]       Rn_ID,
  input  logic [4:0]       Rm_ID,
  input  logic             usesRm_ID,
  input  logic             branchTakenEX,
  input  logic             memReqMEM,
  input  logic             memReadyMEM,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             pipeHold,
  output logic             memwbBubble,
  output logic             memFault,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  hz_state_t         cur_state;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_inc;
  logic              flush_inc;
  logic              load_use;

  assign load_use = is_load_use(memReadEX, RdEX, Rn_ID, Rm_ID, usesRm_ID);

  // While reset is held the outputs already behave as in RUN.
  assign cur_state = reset ? RUN : state_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    pipeHold    = 1'b0;
    memwbBubble = 1'b0;
    memFault    = 1'b0;

    unique case (cur_state)
      RUN: begin
        if (memReqMEM && !memReadyMEM) begin
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          pipeHold    = 1'b1;
          memwbBubble = 1'b1;
          stall_inc   = 1'b1;
          state_d     = MEM_WAIT;
          // Wait budget is a down-counter; the entry cycle does not consume it.
          wait_d      = WAIT_W'(MEM_TIMEOUT);
        end else if (branchTakenEX) begin
          // The ID instruction is squashed, so any load-use match is moot.
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
          flush_inc  = 1'b1;
        end else if (load_use) begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
          stall_inc  = 1'b1;
        end
      end

      MEM_WAIT: begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        pipeHold  = 1'b1;
        stall_inc = 1'b1;
        if (memReadyMEM) begin
          // Let the completed result into MEM/WB; everything upstream stays put.
          state_d = RUN;
          wait_d  = '0;
        end else begin
          memwbBubble = 1'b1;
          if (wait_q <= WAIT_W'(1)) begin
            state_d = FAULT;
            wait_d  = '0;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
      end

      FAULT: begin
        pcWrite     = 1'b0;
        ifidWrite   = 1'b0;
        pipeHold    = 1'b1;
        memwbBubble = 1'b1;
        memFault    = 1'b1;
      end

      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flushCount)
  );

endmodule
